// File: rtl/ibus_responder.sv
// ibus_responder: memory-side end of the instruction-bus handshake.
// Holds a word-addressed instruction ROM that can be preloaded at any time.
// Accepts one outstanding fetch and answers it LATENCY cycles after acceptance.
// Misaligned and out-of-window fetches are answered with a NOP and a fault pulse.
// Optional feature macro: IBUS_RAND_DELAY_EN adds 0..3 LFSR-chosen extra wait cycles.

typedef struct packed {
    logic        valid;
    logic [63:0] addr;
} ibus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
} ibus_resp_t;

module ibus_responder #(
    parameter int unsigned DEPTH_W = 12,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  ibus_req_t          ireq,
    output ibus_resp_t         iresp,
    input  logic               load_en,
    input  logic [DEPTH_W-1:0] load_idx,
    input  logic [31:0]        load_data,
    output logic               fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [63:0]        req_addr, req_addr_next;
    logic               accept;
    logic               fire;
    logic [3:0]         load_cnt;

    logic [63:0]        rd_addr;
    logic [63:0]        rd_off;
    logic               rd_ok;
    logic [DEPTH_W-1:0] rd_idx;
    logic [31:0]        rd_word;

    logic               rsp_ok;
    logic [31:0]        rsp_data;
    logic               rsp_fault;

    logic [31:0]        rom [0:(1<<DEPTH_W)-1];

`ifdef IBUS_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic [4:0]  load_sum;

    // LATENCY=15 plus three extra cycles would not fit the 4-bit counter, so clamp.
    assign load_sum = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
    assign load_cnt = (load_sum > 5'd15) ? 4'd15 : load_sum[3:0];

    // Galois LFSR, stepped once for every latched request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    assign load_cnt = 4'(LATENCY - 1);
`endif

    // Read-side address: a freshly latched address is used directly, otherwise the held one.
    assign rd_addr = accept ? ireq.addr : req_addr;
    assign rd_off  = rd_addr - BASE;
    assign rd_ok   = (rd_addr[1:0] == 2'b00) && (rd_addr >= BASE) &&
                     ((rd_off >> (DEPTH_W + 2)) == 64'd0);
    assign rd_idx  = rd_off[DEPTH_W+1:2];
    // A preload hitting the word being read this cycle wins over the stored copy.
    assign rd_word = (load_en && (load_idx == rd_idx)) ? load_data : rom[rd_idx];

    // Preload port: writes in any state and is unaffected by reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            rom[load_idx] <= load_data;
        end
    end

    // Next-state logic: accept, count down, abort on flush, restart on redirect.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        req_addr_next = req_addr;
        accept        = 1'b0;
        fire          = 1'b0;
        case (state)
            IDLE: begin
                if (ireq.valid) begin
                    accept        = 1'b1;
                    req_addr_next = ireq.addr;
                    cnt_next      = load_cnt;
                    if (load_cnt == 4'd0) begin
                        state_next = RESP;
                        fire       = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!ireq.valid) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (ireq.addr != req_addr) begin
                    accept        = 1'b1;
                    req_addr_next = ireq.addr;
                    cnt_next      = load_cnt;
                    if (load_cnt == 4'd0) begin
                        state_next = RESP;
                        fire       = 1'b1;
                    end
                end else if (cnt <= 4'd1) begin
                    state_next = RESP;
                    cnt_next   = 4'd0;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State, request and registered response; data is only reloaded on a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_addr  <= 64'd0;
            rsp_ok    <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_data  <= 32'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_addr  <= req_addr_next;
            rsp_ok    <= fire;
            rsp_fault <= fire && !rd_ok;
            if (fire) begin
                rsp_data <= rd_ok ? rd_word : NOP;
            end
        end
    end

    assign iresp = {rsp_ok, rsp_ok, rsp_data};
    assign fault = rsp_fault;

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder (DEPTH_W=12, BASE=0x8000_0000, LATENCY=2)
// with a due-cycle reference model checked every cycle.
module tb_ibus_responder;

    localparam int          DW      = 12;
    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam int          LAT     = 2;
    localparam logic [63:0] WIN_END = BASE + (64'd4 << DW);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic [63:0]   addr = 64'd0;
    logic [64:0]   ireq;
    logic [33:0]   iresp;
    logic          load_en = 1'b0;
    logic [DW-1:0] load_idx = '0;
    logic [31:0]   load_data = 32'd0;
    logic          fault;
    logic          ok, aok;
    logic [31:0]   rdata;

    assign ireq  = {valid, addr};
    assign aok   = iresp[33];
    assign ok    = iresp[32];
    assign rdata = iresp[31:0];

    ibus_responder #(.DEPTH_W(DW), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle counter and data_ok pulse log.
    int cyc = 0;
    int ok_cycs[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ok) ok_cycs.push_back(cyc);

    // Reference model: a request is due LAT cycles after it was (re)latched.
    logic [31:0] shadow [0:(1<<DW)-1];
    bit          busy;
    int          due, mc;
    logic [63:0] m_addr;
    logic        m_ok, m_fault;
    logic [31:0] m_data;
    logic [DW-1:0] m_idx;
    bit          started = 0;

    always @(posedge clk) if (load_en) shadow[load_idx] <= load_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy = 0; mc = 0; due = 0; m_addr = 0;
            m_ok = 0; m_fault = 0; m_data = 0;
        end else begin
            if (busy && mc == due) busy = 0;
            else if (busy) begin
                if (!valid) busy = 0;
                else if (addr != m_addr) begin m_addr = addr; due = mc + LAT; end
            end else if (valid) begin
                busy = 1; m_addr = addr; due = mc + LAT;
            end
            mc++;
            m_ok = busy && (due == mc);
            m_fault = 0;
            if (m_ok) begin
                if (m_addr[1:0] != 2'b00 || m_addr < BASE || m_addr >= WIN_END) begin
                    m_fault = 1;
                    m_data  = 32'h0000_0013;
                end else begin
                    m_idx  = DW'((m_addr - BASE) >> 2);
                    m_data = (load_en && load_idx == m_idx) ? load_data : shadow[m_idx];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("data_ok", ok, m_ok);
            check("addr_ok", aok, m_ok);
            check("fault", fault, m_fault);
            check("data", rdata, m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        tick();
        load_en = 1; load_idx = DW'(idx); load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic do_req(input logic [63:0] a, output int lat, output logic [31:0] d, output logic f);
        int t0;
        tick();
        valid = 1; addr = a; t0 = cyc; lat = -1; d = 0; f = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ok) begin
                lat = cyc - t0; d = rdata; f = fault;
                break;
            end
        end
        valid = 0;
    endtask

    initial begin
        int lat, t0, p0;
        logic [31:0] d;
        logic f;

        #3 reset = 0;
        started = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_ok", ok, 0);
        check("rst_addr_ok", aok, 0);
        check("rst_data", rdata, 0);
        check("rst_fault", fault, 0);
        tick();
        reset = 1;

        load(0, 32'h0010_0093);
        load(1, 32'h1111_1111);
        load(2, 32'h2222_2222);
        load(3, 32'h3333_3333);
        load(4095, 32'h1234_5678);

        // Basic fetch of word 0.
        do_req(BASE, lat, d, f);
        check("w0_lat", lat, 2);
        check("w0_data", d, 32'h0010_0093);
        check("w0_fault", f, 0);
        tick();
        check("w0_drop", ok, 0);
        check("w0_hold", rdata, 32'h0010_0093);

        // Faulting addresses.
        do_req(BASE + 2, lat, d, f);
        check("mis_lat", lat, 2);
        check("mis_data", d, 32'h0000_0013);
        check("mis_fault", f, 1);
        do_req(WIN_END, lat, d, f);
        check("end_lat", lat, 2);
        check("end_data", d, 32'h0000_0013);
        check("end_fault", f, 1);
        do_req(BASE - 4, lat, d, f);
        check("below_data", d, 32'h0000_0013);
        check("below_fault", f, 1);
        do_req(WIN_END - 4, lat, d, f);
        check("last_data", d, 32'h1234_5678);
        check("last_fault", f, 0);

        // Flush: drop valid one cycle after acceptance.
        tick();
        valid = 1; addr = BASE + 8; p0 = ok_cycs.size();
        tick();
        valid = 0;
        repeat (5) tick();
        check("flush_pulses", 64'(ok_cycs.size() - p0), 0);
        do_req(BASE + 8, lat, d, f);
        check("after_flush_lat", lat, 2);
        check("after_flush_data", d, 32'h2222_2222);

        // Redirect: new address one cycle after acceptance.
        tick();
        valid = 1; addr = BASE + 8; t0 = cyc; p0 = ok_cycs.size();
        tick();
        addr = BASE + 12;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ok) begin lat = cyc - t0; d = rdata; break; end
        end
        valid = 0;
        repeat (4) tick();
        check("redir_lat", lat, 3);
        check("redir_data", d, 32'h3333_3333);
        check("redir_pulses", 64'(ok_cycs.size() - p0), 1);

        // Forward: preload word 1 in the read cycle of its fetch.
        tick();
        valid = 1; addr = BASE + 4;
        tick();
        load_en = 1; load_idx = DW'(1); load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 0;
        check("fwd_ok", ok, 1);
        check("fwd_data", rdata, 32'hDEAD_BEEF);
        check("fwd_fault", fault, 0);
        valid = 0;
        do_req(BASE + 4, lat, d, f);
        check("fwd_stored", d, 32'hDEAD_BEEF);

        // Back-to-back: valid held high answers at t+2 and t+5.
        tick();
        valid = 1; addr = BASE; t0 = cyc; p0 = ok_cycs.size();
        repeat (7) tick();
        valid = 0;
        repeat (3) tick();
        check("b2b_pulses", 64'(ok_cycs.size() - p0), 2);
        if (ok_cycs.size() >= p0 + 2) begin
            check("b2b_first", 64'(ok_cycs[p0] - t0), 2);
            check("b2b_second", 64'(ok_cycs[p0+1] - t0), 5);
        end

        // Asynchronous reset while waiting.
        tick();
        valid = 1; addr = BASE + 12;
        tick();
        #1 reset = 0;
        #1;
        check("arst_data_ok", ok, 0);
        check("arst_data", rdata, 0);
        check("arst_fault", fault, 0);
        valid = 0;
        tick();
        tick();
        reset = 1;
        p0 = ok_cycs.size();
        repeat (5) tick();
        check("arst_pulses", 64'(ok_cycs.size() - p0), 0);
        do_req(BASE, lat, d, f);
        check("arst_rom_kept_lat", lat, 2);
        check("arst_rom_kept", d, 32'h0010_0093);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Instruction-bus responder: the memory-side end of the `ibus_req_t`/`ibus_resp_t` handshake that the fetch stage drives. It holds a word-addressed instruction ROM, accepts one outstanding fetch at a time, and returns the 32-bit instruction word with `data_ok` after a programmable latency. It sits between the fetch stage and the simulation top, replacing the external memory model for pipeline bring-up. A preload port lets the bench fill the ROM before or during a run.

## Interface
- `DEPTH_W`, default 12: ROM holds 2^DEPTH_W 32-bit words. The byte window is [BASE, BASE + 4·2^DEPTH_W).
- `BASE`, default 64'h8000_0000: byte address of word 0.
- `LATENCY`, default 2, legal range 1..15: cycles from request acceptance to `data_ok`.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ireq` in `ibus_req_t`: uses `valid` and 64-bit `addr`.
- `iresp` out `ibus_resp_t`: `addr_ok`, `data_ok` and 32-bit `data`.
- `load_en` in 1: preload write strobe.
- `load_idx` in DEPTH_W: preload word index.
- `load_data` in 32: preload word.
- `fault` out 1: pulses high together with `data_ok` when the response is a fault substitute.

## Operation
- FSM has three states:
  - IDLE: `valid`=1 accepts the request. It latches `addr` into `req_addr`, loads `cnt`=LATENCY−1 and moves to WAIT if LATENCY>1, or straight to RESP if LATENCY=1.
  - WAIT: `cnt` decrements each cycle. When `cnt` reaches 1 the FSM moves to RESP.
  - RESP: `data_ok`=`addr_ok`=1 for exactly one cycle, then IDLE.
- The initiator must hold `valid` and `addr` stable until it sees `data_ok`. Violations are handled as follows:
  - `valid` drops in WAIT (fetch flush): abort, return to IDLE, no `data_ok`.
  - `addr` differs from `req_addr` in WAIT: restart. Latch the new address, reload `cnt`, stay or enter WAIT. Only the newest address is answered.
  - In RESP the response is committed; `valid`/`addr` changes that cycle are ignored.
- ROM read happens on the WAIT→RESP (or IDLE→RESP) transition, into a registered `rdata`.
- The response word is computed in this order:
  - `req_addr[1:0]`≠0 or address outside the window: data=32'h0000_0013 (NOP) and `fault`=1.
  - Otherwise: data = ROM[(req_addr−BASE)>>2], with the index truncated to DEPTH_W bits after the range check.
- Preload:
  - `load_en` writes ROM[`load_idx`] at the clock edge, in any state.
  - A write in the same cycle as the read of the same word forwards `load_data` to the response.
- After RESP the FSM is in IDLE. A `valid` seen there, even with the same address, is a new request. Back-to-back throughput is one word per LATENCY+1 cycles.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, `cnt`=0, `req_addr`=0.
  - `data_ok`=0, `addr_ok`=0, `data`=0, `fault`=0.
  - ROM contents are not cleared.
- Outputs are registered. `data`, `fault` and `data_ok` are valid in the same cycle. `data` holds its last value after `data_ok` drops.
- Request accepted in cycle t → `data_ok` high in cycle t+LATENCY, low in t+LATENCY+1.
- Reset asserted mid-request: the response is dropped, with no `data_ok` after release until a new request arrives.
- Wrap-around: `cnt` is 4 bits and never underflows; LATENCY=1 bypasses WAIT.
- Window check uses the full 64-bit compare. Addresses at or below BASE−4 and at or above the window end fault.

## Configuration
- `IBUS_RAND_DELAY_EN`: when defined, a 16-bit Galois LFSR (seed 16'hACE1 on reset, taps 0xB400) adds 0..3 extra WAIT cycles per request.
  - The extra count is taken from `lfsr[1:0]` at acceptance.
  - The LFSR advances once per accepted request.
- When not defined, latency is exactly LATENCY and no LFSR is built.

## Test plan
- Reset, preload ROM[0]=32'h0010_0093, LATENCY=2, `valid`=1 with addr=BASE at cycle t → `data_ok`=1 with data=32'h0010_0093 at t+2 only, `fault`=0.
- Misaligned addr=BASE+2 → `data_ok` at t+2 with data=32'h0000_0013 and `fault`=1. Repeat with addr=BASE+4·2^DEPTH_W for the same result.
- Flush: request BASE+8, drop `valid` at t+1 → no `data_ok` through t+5, FSM in IDLE.
- Redirect: request BASE+8, change addr to BASE+12 at t+1 → single `data_ok` at t+3 carrying ROM[3].
- Forward: `load_en` writes idx 1 with 32'hDEAD_BEEF in the read cycle of request BASE+4 → response data=32'hDEAD_BEEF.
- Async reset pulsed while in WAIT → outputs zero immediately, no `data_ok` after release. With `IBUS_RAND_DELAY_EN`, 100 requests all complete within LATENCY..LATENCY+3 cycles.
